reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/tomasulo_pkg.sv | 35 +++
 rtl/rob_ptr_ctl.sv | 81 ++++++++
 rtl/reorder_buffer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared widths, opcode classes and ROB entry layout for the Tomasulo back end.
// The ROB_BRANCH_FLUSH_EN macro is consumed by reorder_buffer, not here.
package tomasulo_pkg;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned FUNC_W = 4;

  typedef enum logic [1:0] {
    CLS_ADD    = 2'b00,
    CLS_MUL    = 2'b01,
    CLS_BRANCH = 2'b10,
    CLS_RSVD   = 2'b11
  } func_class_e;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // Opcode class lives in the top two bits of func.
  function automatic func_class_e func_class(input logic [FUNC_W-1:0] f);
    return func_class_e'(f[FUNC_W-1 -: 2]);
  endfunction

  function automatic logic writes_reg(input logic [FUNC_W-1:0] f);
    return (func_class(f) == CLS_ADD) || (func_class(f) == CLS_MUL);
  endfunction

endpackage

// File: rtl/rob_ptr_ctl.sv
// Head/tail pointers and occupancy for the reorder buffer.
// full/empty/alloc_ready come from the occupancy count, never from pointer equality.
module rob_ptr_ctl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             i_alloc,
  input  logic             i_commit,
  input  logic             i_flush,
  output logic [TAG_W-1:0] o_head,
  output logic [TAG_W-1:0] o_tail,
  output logic [TAG_W:0]   o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_alloc_ready
);

  localparam logic [TAG_W:0] LP_FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_alloc_ready;

  logic [TAG_W-1:0] w_head_nxt;
  logic [TAG_W-1:0] w_tail_nxt;
  logic [TAG_W:0]   w_count_nxt;

  // A flush restarts the window just past the retiring branch.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (i_commit) begin
      w_head_nxt = r_head + TAG_W'(1);
    end
    if (i_flush) begin
      w_tail_nxt  = w_head_nxt;
      w_count_nxt = '0;
    end else begin
      if (i_alloc) begin
        w_tail_nxt = r_tail + TAG_W'(1);
      end
      case ({i_alloc, i_commit})
        2'b10:   w_count_nxt = r_count + (TAG_W+1)'(1);
        2'b01:   w_count_nxt = r_count - (TAG_W+1)'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_alloc_ready <= 1'b1;
    end else begin
      r_head        <= w_head_nxt;
      r_tail        <= w_tail_nxt;
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == LP_FULL);
      r_empty       <= (w_count_nxt == '0);
      r_alloc_ready <= (w_count_nxt != LP_FULL);
    end
  end

  assign o_head        = r_head;
  assign o_tail        = r_tail;
  assign o_count       = r_count;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_alloc_ready = r_alloc_ready;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete from the CDB, retire from head.
// Define ROB_BRANCH_FLUSH_EN to squash younger entries when a taken-mispredict branch retires.
module reorder_buffer #(
  parameter int unsigned DEPTH  = tomasulo_pkg::DEPTH,
  parameter int unsigned DATA_W = tomasulo_pkg::DATA_W,
  parameter int unsigned TAG_W  = tomasulo_pkg::TAG_W,
  parameter int unsigned REG_W  = tomasulo_pkg::REG_W,
  parameter int unsigned FUNC_W = tomasulo_pkg::FUNC_W
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [FUNC_W-1:0] alloc_func,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  query_tag,
  output logic              query_ready,
  output logic [DATA_W-1:0] query_data,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              flush
);

  import tomasulo_pkg::*;

  rob_entry_t r_rob [DEPTH];

  logic [TAG_W-1:0]  w_head;
  logic [TAG_W-1:0]  w_tail;
  logic              w_alloc_ready;
  rob_entry_t        w_head_ent;
  logic              w_commit;
  logic              w_flush;
  logic              w_alloc;
  logic              w_cdb;

  logic              r_commit_valid;
  logic              r_commit_we;
  logic [REG_W-1:0]  r_commit_rd;
  logic [DATA_W-1:0] r_commit_data;
  logic [TAG_W-1:0]  r_commit_tag;

  assign w_head_ent = r_rob[w_head];
  assign w_commit   = w_head_ent.valid && w_head_ent.done;

`ifdef ROB_BRANCH_FLUSH_EN
  logic r_flush;
  assign w_flush = w_commit && (func_class(w_head_ent.func) == CLS_BRANCH) && w_head_ent.data[0];
  assign flush   = r_flush;
`else
  assign w_flush = 1'b0;
  assign flush   = 1'b0;
`endif

  // alloc_ready is registered, so a same-cycle commit cannot open a slot when full.
  assign w_alloc = alloc_valid && w_alloc_ready && !w_flush;
  assign w_cdb   = cdb_valid && r_rob[cdb_tag].valid && !r_rob[cdb_tag].done;

  rob_ptr_ctl #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ptr_ctl (
    .clk1          (clk1),
    .rst_n         (rst_n),
    .i_alloc       (w_alloc),
    .i_commit      (w_commit),
    .i_flush       (w_flush),
    .o_head        (w_head),
    .o_tail        (w_tail),
    .o_count       (count),
    .o_full        (full),
    .o_empty       (empty),
    .o_alloc_ready (w_alloc_ready)
  );

  // Entry storage; commit, CDB and alloc never target the same live slot.
  always_ff @(posedge clk1) begin
    if (!rst_n || w_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else begin
      if (w_commit) begin
        r_rob[w_head] <= '0;
      end
      if (w_cdb) begin
        r_rob[cdb_tag].done <= 1'b1;
        r_rob[cdb_tag].data <= cdb_data;
      end
      if (w_alloc) begin
        r_rob[w_tail] <= rob_entry_t'{valid: 1'b1, done: 1'b0, func: alloc_func,
                                      rd: alloc_rd, data: '0};
      end
    end
  end

  // Retirement port; rd/data/tag hold between commits.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_commit_valid <= 1'b0;
      r_commit_we    <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_data  <= '0;
      r_commit_tag   <= '0;
    end else begin
      r_commit_valid <= w_commit;
      r_commit_we    <= w_commit && writes_reg(w_head_ent.func);
      if (w_commit) begin
        r_commit_rd   <= w_head_ent.rd;
        r_commit_data <= w_head_ent.data;
        r_commit_tag  <= w_head;
      end
    end
  end

`ifdef ROB_BRANCH_FLUSH_EN
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_flush <= 1'b0;
    end else begin
      r_flush <= w_flush;
    end
  end
`endif

  // Operand lookup: a finished entry wins, otherwise forward a matching broadcast.
  always_comb begin
    query_ready = 1'b0;
    query_data  = r_rob[query_tag].data;
    if (r_rob[query_tag].valid && r_rob[query_tag].done) begin
      query_ready = 1'b1;
    end else if (cdb_valid && (cdb_tag == query_tag)) begin
      query_ready = 1'b1;
      query_data  = cdb_data;
    end
  end

  assign alloc_ready  = w_alloc_ready;
  assign alloc_tag    = w_tail;
  assign commit_valid = r_commit_valid;
  assign commit_we    = r_commit_we;
  assign commit_rd    = r_commit_rd;
  assign commit_data  = r_commit_data;
  assign commit_tag   = r_commit_tag;

endmodule
